// File: rtl/side_info_2ch_packer_pkg.sv
// Shared constants, state type and branch-bit helper for the 2-channel side-info packer.
// Pure declarations: no latency, no flow control.
// Fields not used by the selected window-switching branch are dropped here.
package mp3_side_info_pkg;

    localparam int SIDE_INFO_BYTES = 32;
    localparam int CNT_W           = $clog2(SIDE_INFO_BYTES);
    localparam int NGR             = 2;
    localparam int NCH             = 2;
    localparam int SCFSI_BANDS     = 4;

    localparam int MDB_W  = 9;
    localparam int PRIV_W = 3;
    localparam int P23_W  = 12;
    localparam int BIGV_W = 9;
    localparam int GAIN_W = 8;
    localparam int SFC_W  = 4;
    localparam int BT_W   = 2;
    localparam int TS_W   = 5;
    localparam int SBG_W  = 3;
    localparam int R0_W   = 4;
    localparam int R1_W   = 3;
    localparam int BR_W   = 22;
    localparam int GC_W   = P23_W + BIGV_W + GAIN_W + SFC_W + 1 + BR_W + 3;

    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    function automatic logic [BR_W-1:0] branch_bits(
        input logic            ws,
        input logic [BT_W-1:0] bt,
        input logic            mb,
        input logic [TS_W-1:0] ts1,
        input logic [TS_W-1:0] ts2,
        input logic [TS_W-1:0] ts3,
        input logic [SBG_W-1:0] sg1,
        input logic [SBG_W-1:0] sg2,
        input logic [SBG_W-1:0] sg3,
        input logic [R0_W-1:0] r0,
        input logic [R1_W-1:0] r1
    );
        if (ws)
            return {bt, mb, ts1, ts2, sg1, sg2, sg3};
        else
            return {ts1, ts2, ts3, r0, r1};
    endfunction

endpackage

// File: rtl/side_info_2ch_packer_if.sv
// Field-set input, byte-stream output and CRC status bundle for the side-info packer.
// Wires only: no latency, no storage.
// Valid/ready on the field set; axiov/axior on the byte stream.
interface side_info_2ch_packer_if;
    import mp3_side_info_pkg::*;

    logic                                      in_valid;
    logic                                      in_ready;
    logic [MDB_W-1:0]                          main_data_begin;
    logic [PRIV_W-1:0]                         private_bits;
    logic [NCH-1:0][SCFSI_BANDS-1:0]           scfsi;
    logic [NGR-1:0][NCH-1:0][P23_W-1:0]        part2_3_length;
    logic [NGR-1:0][NCH-1:0][BIGV_W-1:0]       big_values;
    logic [NGR-1:0][NCH-1:0][GAIN_W-1:0]       global_gain;
    logic [NGR-1:0][NCH-1:0][SFC_W-1:0]        scalefac_compress;
    logic [NGR-1:0][NCH-1:0]                   window_switching_flag;
    logic [NGR-1:0][NCH-1:0]                   mixed_block_flag;
    logic [NGR-1:0][NCH-1:0]                   preflag;
    logic [NGR-1:0][NCH-1:0]                   scalefac_scale;
    logic [NGR-1:0][NCH-1:0]                   count1table_select;
    logic [NGR-1:0][NCH-1:0][BT_W-1:0]         block_type;
    logic [NGR-1:0][NCH-1:0][TS_W-1:0]         table_select_1;
    logic [NGR-1:0][NCH-1:0][TS_W-1:0]         table_select_2;
    logic [NGR-1:0][NCH-1:0][TS_W-1:0]         table_select_3;
    logic [NGR-1:0][NCH-1:0][SBG_W-1:0]        subblock_gain_1;
    logic [NGR-1:0][NCH-1:0][SBG_W-1:0]        subblock_gain_2;
    logic [NGR-1:0][NCH-1:0][SBG_W-1:0]        subblock_gain_3;
    logic [NGR-1:0][NCH-1:0][R0_W-1:0]         region0_count;
    logic [NGR-1:0][NCH-1:0][R1_W-1:0]         region1_count;
    logic [7:0]                                axiod;
    logic                                      axiov;
    logic                                      axior;
    logic                                      done;
    logic [15:0]                               crc16;
    logic                                      crc_valid;

    modport master (
        output in_valid, main_data_begin, private_bits, scfsi, part2_3_length, big_values,
               global_gain, scalefac_compress, window_switching_flag, mixed_block_flag,
               preflag, scalefac_scale, count1table_select, block_type, table_select_1,
               table_select_2, table_select_3, subblock_gain_1, subblock_gain_2,
               subblock_gain_3, region0_count, region1_count, axior,
        input  in_ready, axiod, axiov, done, crc16, crc_valid
    );

    modport slave (
        input  in_valid, main_data_begin, private_bits, scfsi, part2_3_length, big_values,
               global_gain, scalefac_compress, window_switching_flag, mixed_block_flag,
               preflag, scalefac_scale, count1table_select, block_type, table_select_1,
               table_select_2, table_select_3, subblock_gain_1, subblock_gain_2,
               subblock_gain_3, region0_count, region1_count, axior,
        output in_ready, axiod, axiov, done, crc16, crc_valid
    );

endinterface

// File: rtl/side_info_2ch_packer_crc16.sv
// One-byte CRC-16 step, polynomial 0x8005, MSB first.
// Combinational: zero latency.
// No flow control; caller decides when to register the result.
module crc16_byte
    import mp3_side_info_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [15:0] crc_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        crc_out = c;
    end

endmodule

// File: rtl/side_info_2ch_packer.sv
// Packs a 2-channel side-info field set into 32 bytes, MSB first; optional CRC under SIDE_INFO_CRC_EN.
// Latency: first byte valid 1 cycle after accept, one byte per cycle while axior is high.
// Backpressure: axiod/axiov hold while axior low; in_ready low for the whole frame.
module side_info_2ch_packer
    import mp3_side_info_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    side_info_2ch_packer_if.slave bus
);

    state_t                             state, state_nxt;
    logic [SIDE_INFO_BYTES-1:0][7:0]    image, image_nxt;
    logic [CNT_W-1:0]                   cnt;
    logic                               done_q;
    logic                               accept, hs, last;
    logic [GC_W-1:0]                    gc [NGR*NCH];

    assign accept = bus.in_valid && (state == IDLE);
    assign hs     = (state == SEND) && bus.axior;
    assign last   = hs && (cnt == CNT_W'(SIDE_INFO_BYTES - 1));

    always_comb begin
        for (int g = 0; g < NGR; g++) begin
            for (int c = 0; c < NCH; c++) begin
                gc[g*NCH + c] = {
                    bus.part2_3_length[g][c], bus.big_values[g][c], bus.global_gain[g][c],
                    bus.scalefac_compress[g][c], bus.window_switching_flag[g][c],
                    branch_bits(bus.window_switching_flag[g][c], bus.block_type[g][c],
                                bus.mixed_block_flag[g][c], bus.table_select_1[g][c],
                                bus.table_select_2[g][c], bus.table_select_3[g][c],
                                bus.subblock_gain_1[g][c], bus.subblock_gain_2[g][c],
                                bus.subblock_gain_3[g][c], bus.region0_count[g][c],
                                bus.region1_count[g][c]),
                    bus.preflag[g][c], bus.scalefac_scale[g][c], bus.count1table_select[g][c]
                };
            end
        end
    end

    // scfsi is sent band 0 first, so the packed vector order is reversed here
    assign image_nxt = {
        bus.main_data_begin, bus.private_bits,
        bus.scfsi[0][0], bus.scfsi[0][1], bus.scfsi[0][2], bus.scfsi[0][3],
        bus.scfsi[1][0], bus.scfsi[1][1], bus.scfsi[1][2], bus.scfsi[1][3],
        gc[0], gc[1], gc[2], gc[3]
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            image  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                image <= image_nxt;
                cnt   <= '0;
            end else if (hs) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.axiov    = (state == SEND);
    assign bus.axiod    = image[CNT_W'(SIDE_INFO_BYTES - 1) - cnt];
    assign bus.done     = done_q;

`ifdef SIDE_INFO_CRC_EN
    logic [15:0] crc_q, crc_upd;
    logic        crc_vld_q;

    crc16_byte u_crc (
        .data    (bus.axiod),
        .crc_in  (crc_q),
        .crc_out (crc_upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q     <= CRC_INIT;
            crc_vld_q <= 1'b0;
        end else begin
            crc_vld_q <= last;
            if (accept)
                crc_q <= CRC_INIT;
            else if (hs)
                crc_q <= crc_upd;
        end
    end

    assign bus.crc16     = crc_q;
    assign bus.crc_valid = crc_vld_q;
`else
    assign bus.crc16     = 16'h0000;
    assign bus.crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_side_info_2ch_packer.sv
// Randomized bench for side_info_2ch_packer against a bit-queue reference model and software CRC.
module tb_side_info_2ch_packer;
    import mp3_side_info_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    side_info_2ch_packer_if sif();

    side_info_2ch_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    typedef struct packed {
        logic [8:0]             mdb;
        logic [2:0]             pb;
        logic [1:0][3:0]        scfsi;
        logic [1:0][1:0][11:0]  p23;
        logic [1:0][1:0][8:0]   bigv;
        logic [1:0][1:0][7:0]   gain;
        logic [1:0][1:0][3:0]   sfc;
        logic [1:0][1:0]        wsf;
        logic [1:0][1:0]        mbf;
        logic [1:0][1:0]        pre;
        logic [1:0][1:0]        sfs;
        logic [1:0][1:0]        c1t;
        logic [1:0][1:0][1:0]   bt;
        logic [1:0][1:0][4:0]   ts1;
        logic [1:0][1:0][4:0]   ts2;
        logic [1:0][1:0][4:0]   ts3;
        logic [1:0][1:0][2:0]   sg1;
        logic [1:0][1:0][2:0]   sg2;
        logic [1:0][1:0][2:0]   sg3;
        logic [1:0][1:0][3:0]   r0;
        logic [1:0][1:0][2:0]   r1;
    } frame_t;

`ifdef SIDE_INFO_CRC_EN
    localparam logic [15:0] RST_CRC = 16'hFFFF;
`else
    localparam logic [15:0] RST_CRC = 16'h0000;
`endif

    int         errors = 0;
    int         checks = 0;
    bit         bitq[$];
    logic [7:0] exp_b [32];
    logic [7:0] got_b [32];
    int         rpos;
    frame_t     f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t r;
        for (int i = 0; i < $bits(frame_t); i++) r[i] = 1'($urandom_range(1));
        r.wsf = 4'($urandom_range(1, 14));
        return r;
    endfunction

    task automatic drive(input frame_t d);
        sif.main_data_begin       = d.mdb;
        sif.private_bits          = d.pb;
        sif.scfsi                 = d.scfsi;
        sif.part2_3_length        = d.p23;
        sif.big_values            = d.bigv;
        sif.global_gain           = d.gain;
        sif.scalefac_compress     = d.sfc;
        sif.window_switching_flag = d.wsf;
        sif.mixed_block_flag      = d.mbf;
        sif.preflag               = d.pre;
        sif.scalefac_scale        = d.sfs;
        sif.count1table_select    = d.c1t;
        sif.block_type            = d.bt;
        sif.table_select_1        = d.ts1;
        sif.table_select_2        = d.ts2;
        sif.table_select_3        = d.ts3;
        sif.subblock_gain_1       = d.sg1;
        sif.subblock_gain_2       = d.sg2;
        sif.subblock_gain_3       = d.sg3;
        sif.region0_count         = d.r0;
        sif.region1_count         = d.r1;
    endtask

    task automatic push(input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) bitq.push_back(v[i]);
    endtask

    // Reference: append every transmitted field to a flat bit stream, then cut into bytes
    task automatic build_expected(input frame_t d);
        bitq.delete();
        push(16'(d.mdb), 9);
        push(16'(d.pb), 3);
        for (int ch = 0; ch < 2; ch++)
            for (int b = 0; b < 4; b++) push(16'(d.scfsi[ch][b]), 1);
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 2; c++) begin
                push(16'(d.p23[g][c]), 12);
                push(16'(d.bigv[g][c]), 9);
                push(16'(d.gain[g][c]), 8);
                push(16'(d.sfc[g][c]), 4);
                push(16'(d.wsf[g][c]), 1);
                if (d.wsf[g][c]) begin
                    push(16'(d.bt[g][c]), 2);  push(16'(d.mbf[g][c]), 1);
                    push(16'(d.ts1[g][c]), 5); push(16'(d.ts2[g][c]), 5);
                    push(16'(d.sg1[g][c]), 3); push(16'(d.sg2[g][c]), 3);
                    push(16'(d.sg3[g][c]), 3);
                end else begin
                    push(16'(d.ts1[g][c]), 5); push(16'(d.ts2[g][c]), 5);
                    push(16'(d.ts3[g][c]), 5); push(16'(d.r0[g][c]), 4);
                    push(16'(d.r1[g][c]), 3);
                end
                push(16'(d.pre[g][c]), 1);
                push(16'(d.sfs[g][c]), 1);
                push(16'(d.c1t[g][c]), 1);
            end
        end
        for (int k = 0; k < 32; k++)
            for (int i = 0; i < 8; i++) exp_b[k][7-i] = bitq[8*k + i];
    endtask

    function automatic logic [15:0] sw_crc();
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        foreach (bitq[i]) begin
            fb = c[15] ^ bitq[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    function automatic logic [31:0] rd(input int w);
        logic [31:0] v = '0;
        for (int i = 0; i < w; i++) begin
            v = {v[30:0], got_b[rpos/8][7 - rpos%8]};
            rpos++;
        end
        return v;
    endfunction

    // Parse the received bytes back into fields and compare against what was sent
    task automatic recover(input frame_t d);
        rpos = 0;
        chk("rec_mdb", rd(9), 32'(d.mdb));
        chk("rec_priv", rd(3), 32'(d.pb));
        for (int ch = 0; ch < 2; ch++)
            for (int b = 0; b < 4; b++) chk("rec_scfsi", rd(1), 32'(d.scfsi[ch][b]));
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 2; c++) begin
                chk("rec_p23", rd(12), 32'(d.p23[g][c]));
                chk("rec_bigv", rd(9), 32'(d.bigv[g][c]));
                chk("rec_gain", rd(8), 32'(d.gain[g][c]));
                chk("rec_sfc", rd(4), 32'(d.sfc[g][c]));
                chk("rec_wsf", rd(1), 32'(d.wsf[g][c]));
                if (d.wsf[g][c]) begin
                    chk("rec_bt", rd(2), 32'(d.bt[g][c]));
                    chk("rec_mbf", rd(1), 32'(d.mbf[g][c]));
                    chk("rec_ts1", rd(5), 32'(d.ts1[g][c]));
                    chk("rec_ts2", rd(5), 32'(d.ts2[g][c]));
                    chk("rec_sg1", rd(3), 32'(d.sg1[g][c]));
                    chk("rec_sg2", rd(3), 32'(d.sg2[g][c]));
                    chk("rec_sg3", rd(3), 32'(d.sg3[g][c]));
                end else begin
                    chk("rec_ts1", rd(5), 32'(d.ts1[g][c]));
                    chk("rec_ts2", rd(5), 32'(d.ts2[g][c]));
                    chk("rec_ts3", rd(5), 32'(d.ts3[g][c]));
                    chk("rec_r0", rd(4), 32'(d.r0[g][c]));
                    chk("rec_r1", rd(3), 32'(d.r1[g][c]));
                end
                chk("rec_pre", rd(1), 32'(d.pre[g][c]));
                chk("rec_sfs", rd(1), 32'(d.sfs[g][c]));
                chk("rec_c1t", rd(1), 32'(d.c1t[g][c]));
            end
        end
    endtask

    // Entered and left at a falling edge; abort_after>0 resets mid-frame after that many bytes
    task automatic run_frame(input frame_t d, input bit hold, input int stall_pct, input int abort_after);
        int         n, rx, cyc;
        bit         stalled, r, seen_done;
        logic [7:0] last_d;
        build_expected(d);
        drive(d);
        sif.in_valid = 1'b1;
        n = 0;
        while (!sif.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(sif.in_ready), 32'd1);
        @(negedge clk);
        if (!hold) sif.in_valid = 1'b0;
        drive(rand_frame());
        chk("axiov_after_accept", 32'(sif.axiov), 32'd1);
        chk("done_single_cycle", 32'(sif.done), 32'd0);
        rx = 0; cyc = 0; stalled = 1'b0; last_d = '0;
        while (rx < 32 && cyc < 4000) begin
            if (abort_after > 0 && rx == abort_after) break;
            if (stalled) begin
                chk("stall_axiod", 32'(sif.axiod), 32'(last_d));
                chk("stall_axiov", 32'(sif.axiov), 32'd1);
            end
            chk("busy_in_ready", 32'(sif.in_ready), 32'd0);
            r = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            sif.axior = r;
            if (sif.axiov && r) begin
                got_b[rx] = sif.axiod;
                rx++;
            end
            stalled = sif.axiov && !r;
            last_d  = sif.axiod;
            @(negedge clk);
            cyc++;
        end
        if (abort_after > 0) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_axiov", 32'(sif.axiov), 32'd0);
            chk("rst_axiod", 32'(sif.axiod), 32'd0);
            chk("rst_in_ready", 32'(sif.in_ready), 32'd1);
            chk("rst_done", 32'(sif.done), 32'd0);
            chk("rst_crc16", 32'(sif.crc16), 32'(RST_CRC));
            chk("rst_crc_valid", 32'(sif.crc_valid), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            sif.axior = 1'b1;
            seen_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (sif.done || sif.axiov) seen_done = 1'b1;
            end
            chk("abort_no_done", 32'(seen_done), 32'd0);
            return;
        end
        chk("frame_bytes", 32'(rx), 32'd32);
        if (stall_pct == 0) chk("burst_cycles", 32'(cyc), 32'd32);
        chk("done_pulse", 32'(sif.done), 32'd1);
        chk("end_axiov", 32'(sif.axiov), 32'd0);
        chk("end_in_ready", 32'(sif.in_ready), 32'd1);
        for (int k = 0; k < 32; k++) chk($sformatf("byte%0d", k), 32'(got_b[k]), 32'(exp_b[k]));
`ifdef SIDE_INFO_CRC_EN
        chk("crc_valid", 32'(sif.crc_valid), 32'd1);
        chk("crc16", 32'(sif.crc16), 32'(sw_crc()));
`else
        chk("crc_valid_off", 32'(sif.crc_valid), 32'd0);
        chk("crc16_off", 32'(sif.crc16), 32'd0);
`endif
        sif.axior = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.in_valid = 1'b0;
        sif.axior    = 1'b1;
        drive('0);
        #12;
        chk("reset_axiov", 32'(sif.axiov), 32'd0);
        chk("reset_axiod", 32'(sif.axiod), 32'd0);
        chk("reset_done", 32'(sif.done), 32'd0);
        chk("reset_in_ready", 32'(sif.in_ready), 32'd1);
        chk("reset_crc16", 32'(sif.crc16), 32'(RST_CRC));
        chk("reset_crc_valid", 32'(sif.crc_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        f = '0;
        run_frame(f, 1'b0, 0, 0);

        f = '0;
        f.mdb = 9'h1FF;
        run_frame(f, 1'b0, 0, 0);
        chk("mdb_byte0", 32'(got_b[0]), 32'h0000_00FF);
        chk("mdb_byte1", 32'(got_b[1]), 32'h0000_0080);
        chk("mdb_byte2", 32'(got_b[2]), 32'h0000_0000);

        repeat (4) begin
            f = rand_frame();
            run_frame(f, 1'b0, 0, 0);
            recover(f);
        end

        repeat (3) begin
            f = rand_frame();
            run_frame(f, 1'b1, 40, 0);
            recover(f);
        end
        sif.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        f = rand_frame();
        run_frame(f, 1'b0, 0, 11);

        f = rand_frame();
        run_frame(f, 1'b0, 30, 0);
        recover(f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
